// File: rtl/dram_wb_tester.sv
// Pipelined-Wishbone memory tester: writes (base+i)^seed over a word range, reads it back and compares.
// Results (done/pass/timeout/err_count/first_err_*) are held until the next accepted start.
module dram_wb_tester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_start,
  input  logic [31:0] i_base_adr,
  input  logic [23:0] i_num_words,
  input  logic [31:0] i_seed,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_err_count,
  output logic [31:0] o_first_err_adr,
  output logic [31:0] o_first_err_data,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat_w,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  input  logic [31:0] i_wb_dat_r,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    OUT_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_base, r_seed, r_adr, r_dat_w, r_first_adr, r_first_data;
  logic [23:0]   r_num, r_issued, r_rcv;
  logic [3:0]    r_outst, r_sel;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_err_cnt;
  logic          r_busy, r_done, r_pass, r_timeout, r_cyc, r_stb, r_we;

  logic          w_active, w_start, w_accept, w_resp, w_bad;
  logic          w_stb_nx, w_phase_end, w_tmo_hit;
  logic [23:0]   w_issued_nx, w_rcv_nx;
  logic [3:0]    w_outst_nx;
  logic [15:0]   w_err_nx;
  logic [31:0]   w_rcv_adr, w_adr_nx;

  assign w_active    = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_start     = i_start && i_init_done;
  assign w_accept    = r_stb && !i_wb_stall;
  // Responses with nothing in flight (including late ones after an abort) are dropped.
  assign w_resp      = w_active && (i_wb_ack || i_wb_err) && (r_outst != 4'd0);
  assign w_issued_nx = r_issued + 24'(w_accept);
  assign w_rcv_nx    = r_rcv + 24'(w_resp);
  assign w_outst_nx  = r_outst + 4'(w_accept) - 4'(w_resp);
  assign w_stb_nx    = (w_issued_nx < r_num) && (w_outst_nx < OUT_MAX);
  assign w_phase_end = (w_issued_nx == r_num) && (w_outst_nx == 4'd0);
  assign w_tmo_hit   = (r_tmo == TMO_MAX);
  assign w_rcv_adr   = r_base + 32'(r_rcv);
  assign w_adr_nx    = r_adr + 32'd1;
  assign w_bad       = w_resp && (i_wb_err ||
                       ((r_state == S_READ) && (i_wb_dat_r != (w_rcv_adr ^ r_seed))));
  assign w_err_nx    = (w_bad && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_seed       <= '0;
      r_num        <= '0;
      r_adr        <= '0;
      r_dat_w      <= '0;
      r_first_adr  <= '0;
      r_first_data <= '0;
      r_issued     <= '0;
      r_rcv        <= '0;
      r_outst      <= '0;
      r_sel        <= '0;
      r_tmo        <= '0;
      r_err_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_base       <= i_base_adr;
            r_num        <= i_num_words;
            r_seed       <= i_seed;
            r_issued     <= '0;
            r_rcv        <= '0;
            r_outst      <= '0;
            r_tmo        <= '0;
            r_err_cnt    <= '0;
            r_first_adr  <= '0;
            r_first_data <= '0;
            r_timeout    <= 1'b0;
            if (i_num_words == 24'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_sel   <= 4'hF;
              r_adr   <= i_base_adr;
              r_dat_w <= i_base_adr ^ i_seed;
            end
          end
        end
        S_WRITE, S_READ: begin
          r_issued  <= w_issued_nx;
          r_rcv     <= w_rcv_nx;
          r_outst   <= w_outst_nx;
          r_stb     <= w_stb_nx;
          r_err_cnt <= w_err_nx;
          if (w_bad && (r_err_cnt == 16'd0)) begin
            r_first_adr  <= w_rcv_adr;
            r_first_data <= i_wb_err ? 32'd0 : i_wb_dat_r;
          end
          r_tmo <= (w_resp || (r_outst == 4'd0)) ? '0 : r_tmo + TW'(1);
          if (w_accept) begin
            r_adr   <= w_adr_nx;
            r_dat_w <= (r_state == S_WRITE) ? (w_adr_nx ^ r_seed) : 32'd0;
          end
          if (w_tmo_hit || (w_phase_end && (r_state == S_READ))) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= w_tmo_hit;
            r_pass    <= !w_tmo_hit && (w_err_nx == 16'd0);
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
          end else if (w_phase_end) begin
            r_state <= S_GAP;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
          end
        end
        S_GAP: begin
          r_state  <= S_READ;
          r_issued <= '0;
          r_rcv    <= '0;
          r_outst  <= '0;
          r_tmo    <= '0;
          r_cyc    <= 1'b1;
          r_stb    <= 1'b1;
          r_we     <= 1'b0;
          r_sel    <= 4'hF;
          r_adr    <= r_base;
          r_dat_w  <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_timeout        = r_timeout;
  assign o_err_count      = r_err_cnt;
  assign o_first_err_adr  = r_first_adr;
  assign o_first_err_data = r_first_data;
  assign o_wb_adr         = r_adr;
  assign o_wb_dat_w       = r_dat_w;
  assign o_wb_sel         = r_sel;
  assign o_wb_cyc         = r_cyc;
  assign o_wb_stb         = r_stb;
  assign o_wb_we          = r_we;
endmodule

// File: tb/tb_dram_wb_tester.sv
// Bench for dram_wb_tester: Wishbone responder with random stalls and fixed ack latency, plus a
// scoreboard deriving expected traffic and results from the (base+i)^seed pattern rule.
module tb_dram_wb_tester;
  localparam int MAXO = 4;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        i_rst, i_init_done, i_start;
  logic [31:0] i_base_adr, i_seed;
  logic [23:0] i_num_words;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;
  logic [31:0] o_first_err_adr, o_first_err_data, o_wb_adr, o_wb_dat_w;
  logic [3:0]  o_wb_sel;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] i_wb_dat_r;
  logic        i_wb_stall, i_wb_ack, i_wb_err;

  always #5 clk = ~clk;

  dram_wb_tester #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_init_done(i_init_done), .i_start(i_start),
    .i_base_adr(i_base_adr), .i_num_words(i_num_words), .i_seed(i_seed),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_err_count(o_err_count), .o_first_err_adr(o_first_err_adr),
    .o_first_err_data(o_first_err_data), .o_wb_adr(o_wb_adr), .o_wb_dat_w(o_wb_dat_w),
    .o_wb_sel(o_wb_sel), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .i_wb_dat_r(i_wb_dat_r), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  typedef struct {
    int          due;
    logic        we;
    logic [31:0] adr;
    int          idx;
  } req_t;

  req_t        pq[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0, n_fail = 0;
  int          now = 0, outst = 0, max_outst = 0;
  int          wr_cnt = 0, rd_cnt = 0, gap_cnt = 0, tmo_cnt = 0, last_ack_t = 0, done_t = 0;
  int          stall_pct = 0, lat = 1, m_num = 0, exp_err = 0;
  bit          noack = 0, flip_en = 0, err_en = 0, hold_pend = 0;
  logic [31:0] flip_adr = 0, err_adr = 0, m_base = 0, m_seed = 0, exp_fadr = 0, exp_fdat = 0;
  logic [31:0] hold_adr = 0, hold_dat = 0;
  logic        hold_we = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return (m_base + 32'(i)) ^ m_seed;
  endfunction

  // One clock: observe at the falling edge, then drive responder inputs for the next rising edge.
  task automatic tick();
    req_t        r;
    logic [31:0] d;
    bit          bad, stall_now;
    int          idx;
    bad = 0;
    d = 32'h0;
    @(negedge clk);
    now++;
    if (o_busy && !o_wb_cyc) gap_cnt++;
    if (o_wb_cyc) begin
      chk("outstanding_le_max", 32'(outst <= MAXO), 32'd1);
      if (outst > 0) tmo_cnt++;
    end
    if (hold_pend) begin
      chk("stall_hold_stb", 32'(o_wb_stb), 32'd1);
      chk("stall_hold_adr", o_wb_adr, hold_adr);
      chk("stall_hold_dat", o_wb_dat_w, hold_dat);
      chk("stall_hold_we", 32'(o_wb_we), 32'(hold_we));
    end
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_dat_r = 32'h0;
    if (!noack && pq.size() > 0 && pq[0].due <= now) begin
      r = pq.pop_front();
      outst--;
      if (r.we) i_wb_ack = 1'b1;
      else begin
        if (err_en && r.adr == err_adr) begin
          i_wb_err = 1'b1;
          bad = 1;
        end else begin
          d = mem.exists(r.adr) ? mem[r.adr] : 32'h0;
          if (flip_en && r.adr == flip_adr) d = d ^ 32'h1;
          i_wb_ack = 1'b1;
          i_wb_dat_r = d;
          bad = (d != pat(r.idx));
        end
        if (bad) begin
          if (exp_err == 0) begin
            exp_fadr = m_base + 32'(r.idx);
            exp_fdat = d;
          end
          exp_err++;
        end
        last_ack_t = now;
      end
    end
    stall_now = ($urandom_range(99) < stall_pct);
    i_wb_stall = stall_now;
    if (o_wb_cyc && o_wb_stb && !stall_now) begin
      idx = o_wb_we ? wr_cnt : rd_cnt;
      chk("req_adr", o_wb_adr, m_base + 32'(idx));
      chk("req_dat_w", o_wb_dat_w, o_wb_we ? pat(idx) : 32'h0);
      chk("req_sel", 32'(o_wb_sel), 32'hF);
      if (!o_wb_we) chk("read_after_all_writes", 32'(wr_cnt), 32'(m_num));
      if (o_wb_we) begin
        mem[o_wb_adr] = o_wb_dat_w;
        wr_cnt++;
      end else rd_cnt++;
      r.due = now + lat;
      r.we = o_wb_we;
      r.adr = o_wb_adr;
      r.idx = idx;
      pq.push_back(r);
      outst++;
      if (outst > max_outst) max_outst = outst;
    end
    hold_pend = o_wb_cyc && o_wb_stb && stall_now;
    hold_adr = o_wb_adr;
    hold_dat = o_wb_dat_w;
    hold_we = o_wb_we;
  endtask

  task automatic start_test(input logic [31:0] b, input int n, input logic [31:0] s);
    m_base = b; m_seed = s; m_num = n;
    wr_cnt = 0; rd_cnt = 0; gap_cnt = 0; tmo_cnt = 0; max_outst = 0;
    exp_err = 0; exp_fadr = 0; exp_fdat = 0;
    mem.delete();
    pq.delete();
    outst = 0;
    hold_pend = 0;
    i_base_adr = b;
    i_num_words = n[23:0];
    i_seed = s;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    done_t = now;
    chk("done_within_budget", 32'(o_done), 32'd1);
  endtask

  task automatic check_end(input bit exp_tmo);
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("end_cyc", 32'(o_wb_cyc), 32'd0);
    chk("end_stb", 32'(o_wb_stb), 32'd0);
    chk("end_timeout", 32'(o_timeout), 32'(exp_tmo));
    chk("end_pass", 32'(o_pass), 32'(exp_err == 0 && !exp_tmo));
    chk("end_err_count", 32'(o_err_count), 32'(exp_err));
    chk("end_first_err_adr", o_first_err_adr, exp_fadr);
    chk("end_first_err_data", o_first_err_data, exp_fdat);
  endtask

  initial begin
    logic [31:0] rb;
    int          k;
    i_rst = 1'b1; i_init_done = 1'b1; i_start = 1'b0;
    i_base_adr = 0; i_num_words = 0; i_seed = 0;
    i_wb_dat_r = 0; i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
    repeat (3) tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_pass", 32'(o_pass), 32'd0);
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_err_count", 32'(o_err_count), 32'd0);
    i_rst = 1'b0;
    tick();

    // start is ignored until calibration completes
    i_init_done = 1'b0;
    start_test(32'h10, 4, 32'h1);
    repeat (3) tick();
    chk("noinit_busy", 32'(o_busy), 32'd0);
    chk("noinit_cyc", 32'(o_wb_cyc), 32'd0);
    chk("noinit_done", 32'(o_done), 32'd0);
    i_init_done = 1'b1;

    // zero-length test completes with no bus activity
    start_test(32'h20, 0, 32'h5);
    chk("n0_done", 32'(o_done), 32'd1);
    chk("n0_pass", 32'(o_pass), 32'd1);
    chk("n0_cyc", 32'(o_wb_cyc), 32'd0);
    repeat (3) tick();
    chk("n0_no_requests", 32'(wr_cnt + rd_cnt), 32'd0);

    // zero-wait responder
    stall_pct = 0; lat = 1;
    start_test(32'h100, 8, 32'hA5A5A5A5);
    chk("t1_start_cyc", 32'(o_wb_cyc), 32'd1);
    chk("t1_start_stb", 32'(o_wb_stb), 32'd1);
    chk("t1_start_busy", 32'(o_busy), 32'd1);
    chk("t1_start_done_clr", 32'(o_done), 32'd0);
    wait_done(200);
    check_end(0);
    chk("t1_pass", 32'(o_pass), 32'd1);
    chk("t1_writes", 32'(wr_cnt), 32'd8);
    chk("t1_reads", 32'(rd_cnt), 32'd8);
    chk("t1_gap_cycles", 32'(gap_cnt), 32'd1);
    chk("t1_done_latency", 32'(done_t), 32'(last_ack_t + 1));

    // single-bit corruption on read of 0x103
    flip_en = 1; flip_adr = 32'h103;
    start_test(32'h100, 8, 32'hA5A5A5A5);
    wait_done(200);
    check_end(0);
    chk("t2_err_count", 32'(o_err_count), 32'd1);
    chk("t2_first_adr", o_first_err_adr, 32'h103);
    chk("t2_first_data", o_first_err_data, 32'hA5A5A4A7);
    flip_en = 0;

    // bus error on a read
    err_en = 1; err_adr = 32'h202; lat = 2;
    start_test(32'h200, 6, $urandom);
    wait_done(200);
    check_end(0);
    chk("t7_err_count", 32'(o_err_count), 32'd1);
    chk("t7_first_data", o_first_err_data, 32'h0);
    err_en = 0;

    // outstanding limit reached with long latency
    stall_pct = 0; lat = 8;
    start_test($urandom, 16, $urandom);
    wait_done(500);
    check_end(0);
    chk("t3b_max_outstanding", 32'(max_outst), 32'(MAXO));

    // random stalls, latency 5
    stall_pct = 50; lat = 5;
    start_test($urandom, 64, $urandom);
    wait_done(3000);
    check_end(0);
    chk("t3_pass", 32'(o_pass), 32'd1);
    chk("t3_reads", 32'(rd_cnt), 32'd64);

    // responder never acks
    stall_pct = 0; lat = 1; noack = 1;
    start_test(32'h400, 4, 32'h3C3C3C3C);
    wait_done(3000);
    check_end(1);
    chk("t4_wait_cycles", 32'(tmo_cnt), 32'(TMO + 1));
    chk("t4_writes", 32'(wr_cnt), 32'd4);
    noack = 0;
    repeat (8) tick();
    chk("t4_late_done", 32'(o_done), 32'd1);
    chk("t4_late_timeout", 32'(o_timeout), 32'd1);
    chk("t4_late_err", 32'(o_err_count), 32'd0);
    chk("t4_late_cyc", 32'(o_wb_cyc), 32'd0);

    // reset mid-write, then a fresh run crossing the 32-bit address wrap
    stall_pct = 20; lat = 3;
    rb = $urandom;
    start_test(rb, 32, $urandom);
    k = 0;
    while (wr_cnt < 10 && k < 500) begin
      tick();
      k++;
    end
    chk("t6_reached_word10", 32'(wr_cnt >= 10), 32'd1);
    chk("t6_busy_before_rst", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    pq.delete();
    outst = 0;
    hold_pend = 0;
    tick();
    i_rst = 1'b0;
    chk("t6_rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("t6_rst_stb", 32'(o_wb_stb), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_done", 32'(o_done), 32'd0);
    start_test(32'hFFFFFFF8, 16, $urandom);
    wait_done(1000);
    check_end(0);
    chk("t6_pass", 32'(o_pass), 32'd1);
    chk("t6_writes", 32'(wr_cnt), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
